// File: rtl/btn_conditioner.sv
// btn_conditioner: multi-channel push-button front end.
// Each channel: 2-flop synchroniser -> debouncer -> short/long press classifier.
// A long press on channel TEST_IDX toggles the global test_mode flag.
module btn_conditioner #(
  parameter int unsigned NUM_BTN         = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 3,
  parameter int unsigned TICK_CYCLES     = 50000000,
  parameter int unsigned LONG_TICKS      = 5,
  parameter int unsigned TEST_IDX        = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_BTN-1:0] btn_raw,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] short_pulse,
  output logic [NUM_BTN-1:0] long_pulse,
  output logic               test_mode
);

  localparam int unsigned CNT_W  = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int unsigned TICK_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam int unsigned HOLD_W = $clog2(LONG_TICKS + 1);

  localparam logic [CNT_W-1:0]  DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_TICKS - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PRESSED   = 2'd1,
    LONG_HELD = 2'd2
  } state_e;

  logic test_mode_q;

  for (genvar ch = 0; ch < NUM_BTN; ch++) begin : g_chan
    logic              sync1_q;
    logic              sync2_q;
    logic [CNT_W-1:0]  db_cnt_q;
    logic              level_q;
    logic              level_d;
    state_e            state_q;
    logic [TICK_W-1:0] tick_q;
    logic [HOLD_W-1:0] hold_q;
    logic              short_q;
    logic              long_q;

    // Bring the asynchronous raw level into the clock domain
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        sync1_q <= 1'b0;
        sync2_q <= 1'b0;
      end else begin
        sync1_q <= btn_raw[ch];
        sync2_q <= sync1_q;
      end
    end

    // Debounced level as it will be after this edge; lets the classifier
    // react on the same edge the debounced output changes
    assign level_d = ((sync2_q != level_q) && (db_cnt_q == DB_LAST)) ? sync2_q : level_q;

    // Debouncer: accept a new level only after DEBOUNCE_CYCLES stable samples
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        db_cnt_q <= '0;
        level_q  <= 1'b0;
      end else if (sync2_q == level_q) begin
        db_cnt_q <= '0;
      end else if (db_cnt_q == DB_LAST) begin
        level_q  <= sync2_q;
        db_cnt_q <= '0;
      end else begin
        db_cnt_q <= db_cnt_q + CNT_W'(1);
      end
    end

    // Press classifier: time the debounced hold, emit one registered pulse per press
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        state_q <= IDLE;
        tick_q  <= '0;
        hold_q  <= '0;
        short_q <= 1'b0;
        long_q  <= 1'b0;
      end else begin
        short_q <= 1'b0;
        long_q  <= 1'b0;
        case (state_q)
          IDLE: begin
            if (level_d && !level_q) begin
              state_q <= PRESSED;
              tick_q  <= '0;
              hold_q  <= '0;
            end
          end
          PRESSED: begin
            // Release takes priority over a threshold on the same edge
            if (!level_d) begin
              short_q <= 1'b1;
              state_q <= IDLE;
            end else if (tick_q == TICK_LAST) begin
              tick_q <= '0;
              hold_q <= hold_q + HOLD_W'(1);
              if (hold_q == HOLD_LAST) begin
                long_q  <= 1'b1;
                state_q <= LONG_HELD;
              end
            end else begin
              tick_q <= tick_q + TICK_W'(1);
            end
          end
          LONG_HELD: begin
            if (!level_d) begin
              state_q <= IDLE;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end

    assign btn_level[ch]   = level_q;
    assign short_pulse[ch] = short_q;
    assign long_pulse[ch]  = long_q;
  end

  // Flip test mode the cycle after a long press on the selected channel
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      test_mode_q <= 1'b0;
    end else if (long_pulse[TEST_IDX]) begin
      test_mode_q <= ~test_mode_q;
    end
  end

  assign test_mode = test_mode_q;

endmodule

// File: doc/btn_conditioner.md
Name: btn_conditioner

Overview:
- Parametrised, multi-channel successor to the single-button test-mode detector.
- Each raw push-button input goes through three stages: a 2-flop synchroniser, a debouncer, and a per-channel press classifier.
- The classifier emits one-cycle short-press and long-press pulses.
- A selectable channel toggles a global test-mode flag on long press.
- Sits between the board pushbuttons and the control-unit FSM.

Parameters:
- NUM_BTN, 4: number of independent button channels (1..16).
- DEBOUNCE_CYCLES, 3: consecutive stable cycles needed before the debounced level changes (>=1).
- TICK_CYCLES, 50000000: clock cycles per hold tick, nominally 1 s at 50 MHz (>=1).
- LONG_TICKS, 5: hold ticks that classify a press as long (>=1).
- TEST_IDX, 0: channel whose long press toggles test_mode (< NUM_BTN).

Ports:
- clk  in  1: system clock, all logic on rising edge.
- rst  in  1: asynchronous, active-low reset.
- btn_raw  in  NUM_BTN: raw button levels, 1 = pressed, asynchronous to clk.
- btn_level  out  NUM_BTN: debounced level per channel.
- short_pulse  out  NUM_BTN: 1-cycle pulse on release of a press shorter than long threshold.
- long_pulse  out  NUM_BTN: 1-cycle pulse when hold reaches long threshold.
- test_mode  out  1: toggled by each long press on channel TEST_IDX.

Behaviour:
- Reset (rst=0, async): all synchroniser flops, debounce counters, hold counters, FSMs and outputs go to 0. FSMs go to IDLE.
- Reset mid-press: channel returns to IDLE with no pulse. After release of reset, a still-held button is re-debounced and classified from scratch.

Synchroniser:
- Two flops per channel: s1 <= btn_raw, s2 <= s1.

Debouncer (per channel, counter width clog2(DEBOUNCE_CYCLES)+1):
- If s2 == btn_level: cnt <= 0.
- Else if cnt == DEBOUNCE_CYCLES-1: btn_level <= s2, cnt <= 0.
- Else: cnt <= cnt+1.
- Latency: a clean raw edge reaches btn_level on the (2+DEBOUNCE_CYCLES)th rising edge after capture.
- Glitches shorter than DEBOUNCE_CYCLES cycles at s2 are never seen on btn_level.

Classifier FSM (per channel): states IDLE, PRESSED, LONG_HELD.
- IDLE -> PRESSED: on btn_level 0->1. Clear tick_cnt and hold_ticks.
- PRESSED:
  - tick_cnt increments each cycle.
  - On tick_cnt == TICK_CYCLES-1: tick_cnt <= 0, hold_ticks <= hold_ticks+1.
  - When hold_ticks would reach LONG_TICKS: long_pulse=1 for exactly one cycle, go to LONG_HELD.
- PRESSED with btn_level==0: short_pulse=1 for one cycle, go to IDLE.
- LONG_HELD: counters frozen. On btn_level==0, go to IDLE with no pulse. At most one long_pulse per press.
- Long threshold = LONG_TICKS*TICK_CYCLES cycles of debounced hold. The threshold cycle is the rising edge on which the final tick increment occurs; long_pulse is registered and asserted on the following cycle.
- Simultaneous release and threshold on the same edge: release wins, short_pulse issued, no long_pulse.
- Pulses are registered outputs. short_pulse and long_pulse are never both high on one channel.
- hold_ticks width is clog2(LONG_TICKS+1); it cannot exceed LONG_TICKS.
- Channels are fully independent; simultaneous events on different channels are all reported in the same cycle.

Test mode:
- test_mode <= ~test_mode in the cycle after long_pulse[TEST_IDX] is asserted.
- Long presses on other channels have no effect on test_mode.

Test Plan:
1. Params NUM_BTN=2, DEBOUNCE_CYCLES=3, TICK_CYCLES=4, LONG_TICKS=5. Drive 2-cycle glitches of btn_raw[0] three times -> btn_level[0] stays 0, no pulses.
2. Hold btn_raw[0] for 10 cycles, then release -> btn_level[0] rises 5 edges after capture. Exactly one short_pulse[0] after debounced release. long_pulse=0, test_mode=0.
3. Hold btn_raw[0] for 40 cycles -> one long_pulse[0] 20 cycles after btn_level[0] rises. test_mode goes 1 the next cycle. No short_pulse on release.
4. Repeat scenario 3 -> test_mode returns to 0. Long press on channel 1 -> long_pulse[1] fires, test_mode unchanged.
5. Press both channels in the same cycle: channel 0 short (8 cycles), channel 1 long (30 cycles) -> short_pulse[0] and long_pulse[1] fire independently at their computed cycles.
6. Assert rst=0 asynchronously 12 cycles into a long press -> all outputs 0 immediately. Release reset with button held -> long_pulse fires 2+3+20 cycles after reset release, plus register delay.
